// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter: FSM encoding,
// parity modes, word-size limits and the word-size clamp.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned WORD_MIN = 5;
  localparam int unsigned WORD_MAX = 9;

  function automatic logic [3:0] clamp_size(input logic [3:0] req, input logic [3:0] max_w);
    if (req < 4'(WORD_MIN)) return 4'(WORD_MIN);
    else if (req > max_w) return max_w;
    else return req;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Power-of-two synchronous FIFO used as the transmit queue.
// Pushes while full and pops while empty are ignored.
module uart_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter. Define UART_TX_BUFFERED_FIFO_EN for a FIFO_DEPTH-entry
// queue; otherwise a single holding register buffers one word.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned MAX_WORD   = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [DIV_W-1:0]                  i_baud_div,
  input  logic [3:0]                        i_cfg_word_size,
  input  logic [1:0]                        i_cfg_parity,
  input  logic                              i_cfg_stop2,
  input  logic [MAX_WORD-1:0]               i_tx_data,
  input  logic                              i_tx_valid,
  output logic                              o_tx_ready,
  output logic                              o_tx,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                r_rst_done;
  logic                w_not_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [MAX_WORD-1:0] w_head;
  logic [CNT_W-1:0]    w_count;

  assign o_tx_ready   = r_rst_done & w_not_full;
  assign o_fifo_count = w_count;
  assign w_push       = i_tx_valid & o_tx_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rst_done <= 1'b0;
    else       r_rst_done <= 1'b1;
  end

`ifdef UART_TX_BUFFERED_FIFO_EN
  logic w_full;

  uart_fifo #(
    .WIDTH (MAX_WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_tx_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_not_full = ~w_full;
`else
  logic                r_hold_valid;
  logic [MAX_WORD-1:0] r_hold_data;

  // Push needs an empty slot and pop needs a full one, so they never coincide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_push) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= i_tx_data;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign w_not_full = ~r_hold_valid;
  assign w_empty    = ~r_hold_valid;
  assign w_head     = r_hold_data;
  assign w_count    = CNT_W'(r_hold_valid);
`endif

  uart_state_e         r_state;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_baud_cnt;
  logic [3:0]          r_bit_cnt;
  logic [3:0]          r_size;
  logic [1:0]          r_par;
  logic                r_stop2;
  logic [MAX_WORD-1:0] r_shift;
  logic                r_par_bit;
  logic                r_tx;

  logic                w_tick;
  logic                w_last_stop;
  logic [3:0]          w_size;
  logic [MAX_WORD-1:0] w_masked;
  logic                w_tx_next;

  assign w_tick      = (r_baud_cnt == r_div);
  assign w_last_stop = (r_state == StStop) && w_tick && (!r_stop2 || r_bit_cnt[0]);
  assign w_pop       = !w_empty && ((r_state == StIdle) || w_last_stop);
  assign w_size      = clamp_size(i_cfg_word_size, 4'(MAX_WORD));
  assign o_tx        = r_tx;
  assign o_busy      = (r_state != StIdle);

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < int'(MAX_WORD); i++) begin
      w_masked[i] = w_head[i] & (4'(i) < w_size);
    end
  end

  always_comb begin
    w_tx_next = 1'b1;
    unique case (r_state)
      StStart:  w_tx_next = 1'b0;
      StData:   w_tx_next = r_shift[0];
      StParity: w_tx_next = r_par_bit;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // o_tx follows the state by one clock, keeping the line a clean flop output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_size     <= '0;
      r_par      <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      if (w_pop) begin
        r_state    <= StStart;
        r_div      <= i_baud_div;
        r_size     <= w_size;
        r_par      <= i_cfg_parity;
        r_stop2    <= i_cfg_stop2;
        r_shift    <= w_masked;
        r_par_bit  <= (^w_masked) ^ (i_cfg_parity == PAR_ODD);
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (r_state != StIdle) begin
        if (!w_tick) begin
          r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end else begin
          r_baud_cnt <= '0;
          unique case (r_state)
            StStart: begin
              r_state   <= StData;
              r_bit_cnt <= '0;
            end
            StData: begin
              r_shift <= r_shift >> 1;
              if (r_bit_cnt == r_size - 4'd1) begin
                r_bit_cnt <= '0;
                r_state   <= ((r_par == PAR_EVEN) || (r_par == PAR_ODD)) ? StParity : StStop;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
            StParity: begin
              r_state   <= StStop;
              r_bit_cnt <= '0;
            end
            StStop: begin
              if (w_last_stop) r_state <= StIdle;
              else             r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            default: r_state <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues expected frames built from
// the framing rules, a monitor decodes o_tx and compares frame by frame.
module tb_uart_tx_buffered;

`ifdef UART_TX_BUFFERED_FIFO_EN
  localparam int EFF_DEPTH = 8;
`else
  localparam int EFF_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = '0;
  logic [3:0]  cfg_size = 4'd8;
  logic [1:0]  cfg_par = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic [8:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_count;

  uart_tx_buffered #(
    .MAX_WORD   (9),
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_baud_div      (baud_div),
    .i_cfg_word_size (cfg_size),
    .i_cfg_parity    (cfg_par),
    .i_cfg_stop2     (cfg_stop2),
    .i_tx_data       (tx_data),
    .i_tx_valid      (tx_valid),
    .o_tx_ready      (tx_ready),
    .o_tx            (tx),
    .o_busy          (busy),
    .o_fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          period;
    bit          contig;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   frame_id = 0;
  bit   stalled = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference frame: start, masked data LSB first, optional parity, stop bit(s).
  function automatic exp_t model(input int d, input int sz, input int par, input bit st2,
                                 input int div, input bit contig);
    exp_t e;
    int eff, dm, n, p;
    eff = (sz < 5) ? 5 : ((sz > 9) ? 9 : sz);
    dm = d & ((1 << eff) - 1);
    e.bits = '0;
    n = 1;
    for (int i = 0; i < eff; i++) begin
      e.bits[n] = ((dm >> i) & 1) != 0;
      n++;
    end
    if (par == 1 || par == 2) begin
      p = $countones(dm) % 2;
      if (par == 2) p = 1 - p;
      e.bits[n] = (p != 0);
      n++;
    end
    e.bits[n] = 1'b1;
    n++;
    if (st2) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = n;
    e.period = div + 1;
    e.contig = contig;
    return e;
  endfunction

  task automatic set_cfg(input int sz, input int par, input bit st2, input int div);
    cfg_size = 4'(sz);
    cfg_par = 2'(par);
    cfg_stop2 = st2;
    baud_div = 16'(div);
  endtask

  // Expectation carries the config that will be latched when this word is popped.
  task automatic push_word(input int d, input int sz, input int par, input bit st2,
                           input int div, input bit contig, input bit track);
    int w = 0;
    bit first = 1;
    @(negedge clk);
    tx_data = 9'(d);
    tx_valid = 1'b1;
    while (!tx_ready && w < 5000) begin
      if (first) begin
        check("count when not ready", 32'(fifo_count), 32'(EFF_DEPTH));
        stalled = 1;
        first = 0;
      end
      @(negedge clk);
      w++;
    end
    if (w >= 5000) begin
      check("push timeout", 32'(tx_ready), 32'd1);
    end else begin
      @(posedge clk);
      if (track) sb_q.push_back(model(d, sz, par, st2, div, contig));
    end
    #1 tx_valid = 1'b0;
  endtask

  task automatic monitor(input int n);
    for (int f = 0; f < n; f++) begin
      int w = 0;
      exp_t e;
      @(negedge clk);
      while (tx !== 1'b0 && w < 4000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 4000) begin
        check("start bit timeout", 32'(tx), 32'd0);
        return;
      end
      if (sb_q.size() == 0) begin
        check("unexpected frame", 32'd1, 32'd0);
        return;
      end
      e = sb_q.pop_front();
      if (e.contig) check($sformatf("frame%0d idle gap", frame_id), 32'(w), 32'd0);
      for (int b = 0; b < e.nbits; b++) begin
        logic got = e.bits[b];
        for (int k = 0; k < e.period; k++) begin
          if (b > 0 || k > 0) @(negedge clk);
          if (tx !== e.bits[b]) got = tx;
        end
        check($sformatf("frame%0d bit%0d", frame_id, b), 32'(got), 32'(e.bits[b]));
      end
      frame_id++;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || fifo_count != 0) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20000) check("idle timeout", 32'(busy), 32'd0);
  endtask

  int grp_n[8];
  int grp_sz[8];
  int grp_par[8];
  bit grp_st2[8];
  int grp_div[8];
  int rnd_total = 0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset o_tx", 32'(tx), 32'd1);
    check("reset o_busy", 32'(busy), 32'd0);
    check("reset count", 32'(fifo_count), 32'd0);
    check("reset ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("ready after release", 32'(tx_ready), 32'd1);

    // 0x0A5, 8 bits, even parity, div 3: latency and 44-clock frame
    set_cfg(8, 1, 0, 3);
    fork
      begin
        int cnt = 0;
        push_word(9'h0A5, 8, 1, 0, 3, 0, 1);
        @(negedge clk);
        check("tx high before pop", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx high at pop edge", 32'(tx), 32'd1);
        while (busy && cnt < 1000) begin
          cnt++;
          if (cnt == 2) check("tx low 2 edges after accept", 32'(tx), 32'd0);
          @(negedge clk);
        end
        check("frame length clocks", 32'(cnt), 32'd44);
      end
      monitor(1);
    join
    wait_idle();

    // 5 bits, odd parity, two stop bits
    set_cfg(5, 2, 1, 2);
    fork
      push_word(9'h1FF, 5, 2, 1, 2, 0, 1);
      monitor(1);
    join
    wait_idle();

    // Word-size clamping
    fork
      begin
        set_cfg(12, 0, 0, 1);
        push_word(9'h1C3, 12, 0, 0, 1, 0, 1);
        wait_idle();
        set_cfg(2, 1, 0, 1);
        push_word(9'h0FF, 2, 1, 0, 1, 0, 1);
      end
      monitor(2);
    join
    wait_idle();

    // Back-to-back burst at div 0
    set_cfg(8, 0, 0, 0);
    stalled = 0;
    fork
      for (int i = 0; i < 9; i++) push_word(i * 37 + 5, 8, 0, 0, 0, i > 0, 1);
      monitor(9);
    join
    check("burst stalled on full", 32'(stalled), 32'd1);
    wait_idle();
    check("count back to 0", 32'(fifo_count), 32'd0);

    // Divisor change mid-frame
    set_cfg(6, 1, 0, 1);
    fork
      begin
        int w = 0;
        push_word(9'h02D, 6, 1, 0, 1, 0, 1);
        push_word(9'h013, 6, 1, 0, 7, 1, 1);
        while (tx !== 1'b0 && w < 100) begin
          @(negedge clk);
          w++;
        end
        baud_div = 16'd7;
      end
      monitor(2);
    join
    wait_idle();

    // Randomized groups; config only changes once the queue has drained
    for (int g = 0; g < 8; g++) begin
      grp_n[g] = $urandom_range(1, 3);
      grp_sz[g] = $urandom_range(3, 11);
      grp_par[g] = $urandom_range(0, 3);
      grp_st2[g] = 1'($urandom_range(0, 1));
      grp_div[g] = $urandom_range(0, 3);
      rnd_total += grp_n[g];
    end
    fork
      for (int g = 0; g < 8; g++) begin
        wait_idle_queue();
        set_cfg(grp_sz[g], grp_par[g], grp_st2[g], grp_div[g]);
        for (int k = 0; k < grp_n[g]; k++)
          push_word(int'($urandom_range(0, 511)), grp_sz[g], grp_par[g], grp_st2[g],
                    grp_div[g], k > 0, 1);
      end
      monitor(rnd_total);
    join
    wait_idle();
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-frame with words queued
    set_cfg(8, 0, 0, 3);
    begin
      int w = 0;
      int nq = (EFF_DEPTH < 3) ? EFF_DEPTH : 3;
      int lows = 0;
      for (int i = 0; i <= nq; i++) push_word(9'h055 + i, 8, 0, 0, 3, 0, 0);
      while (tx !== 1'b0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      repeat (12) @(negedge clk);
      check("queued before reset", 32'(fifo_count), 32'(nq));
      #2 rst = 1'b1;
      #1;
      check("async reset o_tx", 32'(tx), 32'd1);
      check("async reset count", 32'(fifo_count), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset ready", 32'(tx_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check("ready after mid reset", 32'(tx_ready), 32'd1);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      check("no frames after reset", 32'(lows), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic wait_idle_queue();
    int w = 0;
    while (fifo_count != 0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20000) check("queue drain timeout", 32'(fifo_count), 32'd0);
  endtask

endmodule
